ofm_tile_collector: RTL and testbench
=====================================

OFM_TILE_COLLECTOR -- requirements
Module: ofm_tile_collector

Interface
REQ-001 Parameter COL, default 4: number of PE-array output columns collected.
REQ-002 Parameter OFM_WIDTH, default 24: bit width of one partial-sum word.
REQ-003 Parameter DEPTH, default 8 (power of two, >=2): entries per column FIFO.
REQ-004 Parameter TILE_LEN, default 16: words per tile line per column.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sum  input  COL*OFM_WIDTH  packed column sums; column c occupies bits [c*OFM_WIDTH +: OFM_WIDTH].
REQ-008 sum_valid  input  COL  per-column write strobe for sum.
REQ-009 cfg_line_burst  input  1  arbitration mode: 0 = per-word round robin, 1 = hold grant for a whole tile line.
REQ-010 clear_err  input  1  clears all overflow flags.
REQ-011 out_ready  input  1  downstream accepts output word.
REQ-012 out_valid  output  1  output word present.
REQ-013 out_data  output  OFM_WIDTH  output word.
REQ-014 out_col  output  max(1,$clog2(COL))  source column of out_data.
REQ-015 out_last  output  1  out_data is the final word of its column's tile line.
REQ-016 col_full  output  COL  per-column FIFO full.
REQ-017 overflow  output  COL  sticky per-column drop indicator.

Function
REQ-018 Each column SHALL own a DEPTH-entry FIFO written when sum_valid[c] is high.
REQ-019 A write to a full FIFO with no pop in the same cycle SHALL be dropped and SHALL set overflow[c]; with a pop in the same cycle, it SHALL be accepted.
REQ-020 Output stage SHALL be a single register; it loads when empty or when out_valid && out_ready (full throughput, one word per cycle).
REQ-021 out_data/out_col/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 Minimum latency: sum_valid in cycle t -> out_valid in cycle t+2.
REQ-023 Mode 0: grant SHALL go to the first non-empty column after the last granted one, cyclically.
REQ-024 Mode 1: once a column is granted, only that column SHALL be popped until its out_last word loads; an empty locked column leaves the output register empty (no other column served).
REQ-025 Arbiter states: IDLE (no lock), LOCKED(col); IDLE->LOCKED on a mode-1 grant not completing the line; LOCKED->IDLE when the last word loads.
REQ-026 cfg_line_burst SHALL be sampled only in IDLE; changes while LOCKED take effect after the line completes.
REQ-027 Each column SHALL keep a line counter 0..TILE_LEN-1 incremented on each pop; out_last=1 when the popped word's counter equals TILE_LEN-1; counter then wraps to 0.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; full/empty from an extra pointer bit.
REQ-029 clear_err SHALL clear overflow; a same-cycle overflow event SHALL win (flag stays set).
REQ-030 col_full[c] SHALL reflect registered FIFO state (no combinational path from sum_valid).

Reset
REQ-031 On rst: FIFOs empty, line counters 0, arbiter IDLE, round-robin pointer to column COL-1 (so column 0 is first), output register empty.
REQ-032 Reset values: out_valid=0, out_data=0, out_col=0, out_last=0, col_full=0, overflow=0.
REQ-033 rst asserted mid-operation SHALL discard all buffered words and any lock in that cycle; writes in the reset cycle are ignored.

Structure
REQ-034 A shared package SHALL hold the sum word typedef (OFM_WIDTH wide) and default constants for COL, DEPTH, TILE_LEN.
REQ-035 The per-column FIFO SHALL be a sub-module ofm_col_fifo, instantiated COL times by generate.

Verification
REQ-036 Mode 0, COL=4, one word 0x000010+c into every column simultaneously, out_ready=1 -> out_col 0,1,2,3 in cycles t+2..t+5, data matches.
REQ-037 Mode 1, TILE_LEN=4, columns 0 and 1 each fed 4 words -> col 0's 4 words consecutive with out_last on the 4th, then col 1's 4 words.
REQ-038 Column 2 fed DEPTH+1=9 words back-to-back, out_ready=0 -> col_full[2]=1 after 8 writes, 9th dropped, overflow[2]=1; clear_err clears it.
REQ-039 out_ready toggled 1/0 each cycle under continuous input -> no word lost or duplicated, outputs stable while stalled.
REQ-040 rst pulsed while mode-1 lock active with 3 words buffered -> next cycle out_valid=0, FIFOs empty, subsequent line counts restart at 0.

Source files
------------

// File: rtl/ofm_tile_collector_pkg.sv
// Shared types and default sizing for the OFM tile collector and its column FIFOs.
// Holds the partial-sum word type, arbiter state encoding and a width helper.
package ofm_tile_collector_pkg;

  localparam int COL_DEF       = 4;
  localparam int OFM_WIDTH_DEF = 24;
  localparam int DEPTH_DEF     = 8;
  localparam int TILE_LEN_DEF  = 16;

  typedef logic [OFM_WIDTH_DEF-1:0] sum_word_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index width that stays legal (>=1 bit) for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofm_col_fifo.sv
// Per-column DEPTH-entry FIFO, show-ahead read, zero-latency pop; full/empty from registered pointers.
// Write while full is accepted only with a same-cycle pop, otherwise dropped and flagged on drop.
module ofm_col_fifo
  import ofm_tile_collector_pkg::*;
#(
  parameter int  DEPTH  = DEPTH_DEF,
  parameter type word_t = sum_word_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  word_t wr_data,
  input  logic  rd_en,
  output word_t rd_data,
  output logic  empty,
  output logic  full,
  output logic  drop
);

  localparam int AW = $clog2(DEPTH);

  word_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop;
  logic        wr_ok;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || pop);
  assign drop    = wr_en && full && !pop;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ofm_tile_collector.sv
// Collects COL column partial-sum streams into one output stream; sum_valid to out_valid is 2 cycles minimum.
// Single output register stalls on !out_ready; full columns drop new words and set a sticky overflow bit.
module ofm_tile_collector
  import ofm_tile_collector_pkg::*;
#(
  parameter  int COL       = COL_DEF,
  parameter  int OFM_WIDTH = OFM_WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int TILE_LEN  = TILE_LEN_DEF,
  localparam int CW        = clog2_min1(COL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COL*OFM_WIDTH-1:0] sum,
  input  logic [COL-1:0]           sum_valid,
  input  logic                     cfg_line_burst,
  input  logic                     clear_err,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [OFM_WIDTH-1:0]     out_data,
  output logic [CW-1:0]            out_col,
  output logic                     out_last,
  output logic [COL-1:0]           col_full,
  output logic [COL-1:0]           overflow
);

  localparam int LW = clog2_min1(TILE_LEN);

  typedef logic [OFM_WIDTH-1:0] word_t;

  word_t      rd_data [COL];
  logic [COL-1:0] empty;
  logic [COL-1:0] pop;
  logic [COL-1:0] drop;
  logic [LW-1:0]  line_cnt [COL];

  arb_state_t state, state_nxt;
  logic [CW-1:0] lock_col, lock_nxt;
  logic [CW-1:0] rr_ptr, rr_col, gnt_col;
  logic          rr_found, rr_last, lock_last;
  logic          gnt, gnt_last, load;

  for (genvar c = 0; c < COL; c++) begin : g_col
    ofm_col_fifo #(
      .DEPTH  (DEPTH),
      .word_t (word_t)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (sum_valid[c]),
      .wr_data (sum[c*OFM_WIDTH +: OFM_WIDTH]),
      .rd_en   (pop[c]),
      .rd_data (rd_data[c]),
      .empty   (empty[c]),
      .full    (col_full[c]),
      .drop    (drop[c])
    );
  end

  assign load = !out_valid || out_ready;

  // Round robin: first non-empty column strictly after the last granted one.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_col   = '0;
    for (int i = 1; i <= COL; i++) begin
      idx = (int'(rr_ptr) + i) % COL;
      if (!rr_found && !empty[idx]) begin
        rr_found = 1'b1;
        rr_col   = CW'(idx);
      end
    end
  end

  assign rr_last   = (line_cnt[rr_col]   == LW'(TILE_LEN - 1));
  assign lock_last = (line_cnt[lock_col] == LW'(TILE_LEN - 1));

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_col;
    gnt       = 1'b0;
    gnt_col   = rr_col;
    gnt_last  = rr_last;
    case (state)
      ARB_IDLE: begin
        if (load && rr_found) begin
          gnt = 1'b1;
          if (cfg_line_burst && !rr_last) begin
            state_nxt = ARB_LOCKED;
            lock_nxt  = rr_col;
          end
        end
      end
      ARB_LOCKED: begin
        // A locked but empty column idles the output rather than serving others.
        gnt_col  = lock_col;
        gnt_last = lock_last;
        if (load && !empty[lock_col]) begin
          gnt = 1'b1;
          if (lock_last) state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    if (gnt) pop[gnt_col] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      lock_col  <= '0;
      rr_ptr    <= CW'(COL - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
      overflow  <= '0;
      for (int c = 0; c < COL; c++) line_cnt[c] <= '0;
    end else begin
      state    <= state_nxt;
      lock_col <= lock_nxt;
      // A drop in the same cycle as clear_err keeps the flag set.
      overflow <= (overflow & ~{COL{clear_err}}) | drop;
      if (gnt) begin
        rr_ptr            <= gnt_col;
        line_cnt[gnt_col] <= gnt_last ? '0 : line_cnt[gnt_col] + LW'(1);
      end
      if (load) begin
        out_valid <= gnt;
        if (gnt) begin
          out_data <= rd_data[gnt_col];
          out_col  <= gnt_col;
          out_last <= gnt_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofm_tile_collector.sv
// Bench for ofm_tile_collector (COL=4, DEPTH=8, TILE_LEN=4): vector table, directed corner sequences,
// and a randomized run, all cross-checked every cycle against a queue-based reference model.
module tb_ofm_tile_collector;
  import ofm_tile_collector_pkg::*;

  localparam int COL = 4;
  localparam int W   = 24;
  localparam int DEP = 8;
  localparam int TL  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [COL*W-1:0] sum;
  logic [COL-1:0]   sum_valid;
  logic             cfg_line_burst;
  logic             clear_err;
  logic             out_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [1:0]       out_col;
  logic             out_last;
  logic [COL-1:0]   col_full;
  logic [COL-1:0]   overflow;

  always #5 clk = ~clk;

  ofm_tile_collector #(.COL(COL), .OFM_WIDTH(W), .DEPTH(DEP), .TILE_LEN(TL)) dut (
    .clk(clk), .rst(rst), .sum(sum), .sum_valid(sum_valid),
    .cfg_line_burst(cfg_line_burst), .clear_err(clear_err), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_col(out_col), .out_last(out_last),
    .col_full(col_full), .overflow(overflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one queue per column, plus arbiter and output-register state.
  sum_word_t      mq [COL][$];
  bit             m_vld;
  sum_word_t      m_data;
  int             m_col, m_lock, m_rr;
  bit             m_last, m_locked;
  int             m_cnt [COL];
  logic [COL-1:0] m_ovf;

  task automatic model_step();
    int        g;
    bit        ld, lst;
    sum_word_t w;
    logic [COL-1:0] dropped;
    g = -1; lst = 0; w = '0; dropped = '0;
    if (rst) begin
      for (int c = 0; c < COL; c++) begin mq[c].delete(); m_cnt[c] = 0; end
      m_vld = 0; m_data = '0; m_col = 0; m_last = 0; m_locked = 0; m_lock = 0;
      m_rr = COL - 1; m_ovf = '0;
      return;
    end
    ld = !m_vld || out_ready;
    if (ld) begin
      if (m_locked) begin
        if (mq[m_lock].size() > 0) g = m_lock;
      end else begin
        for (int i = 1; i <= COL; i++)
          if (g < 0 && mq[(m_rr + i) % COL].size() > 0) g = (m_rr + i) % COL;
      end
    end
    if (g >= 0) begin
      w        = mq[g].pop_front();
      lst      = (m_cnt[g] == TL - 1);
      m_cnt[g] = (m_cnt[g] + 1) % TL;
      m_rr     = g;
      if (m_locked) begin
        if (lst) m_locked = 0;
      end else if (cfg_line_burst && !lst) begin
        m_locked = 1; m_lock = g;
      end
    end
    for (int c = 0; c < COL; c++)
      if (sum_valid[c]) begin
        if (mq[c].size() < DEP) mq[c].push_back(sum[c*W +: W]);
        else dropped[c] = 1'b1;
      end
    m_ovf = (clear_err ? '0 : m_ovf) | dropped;
    if (ld) begin
      m_vld = (g >= 0);
      if (g >= 0) begin m_data = w; m_col = g; m_last = lst; end
    end
  endtask

  task automatic model_check();
    logic [COL-1:0] ef;
    for (int c = 0; c < COL; c++) ef[c] = (mq[c].size() == DEP);
    chk("m_valid", out_valid, m_vld);
    if (m_vld) begin
      chk("m_data", out_data, m_data);
      chk("m_col",  out_col,  m_col);
      chk("m_last", out_last, m_last);
    end
    chk("m_col_full", col_full, ef);
    chk("m_overflow", overflow, m_ovf);
  endtask

  // Words consumed (valid && ready at a clock edge).
  sum_word_t got_d[$];
  int        got_c[$];
  bit        got_l[$];
  int        got_t[$];

  task automatic tick();
    if (out_valid && out_ready) begin
      got_d.push_back(out_data); got_c.push_back(int'(out_col));
      got_l.push_back(out_last); got_t.push_back(cyc);
    end
    model_step();
    @(posedge clk); #1;
    cyc++;
    model_check();
  endtask

  task automatic do_reset();
    rst = 1; sum_valid = '0; sum = '0; clear_err = 0;
    tick();
    rst = 0;
    got_d.delete(); got_c.delete(); got_l.delete(); got_t.delete();
  endtask

  task automatic drain(input int n, input int budget);
    sum_valid = '0; out_ready = 1;
    for (int k = 0; k < budget && got_d.size() < n; k++) tick();
    chk("drain_count", got_d.size(), n);
  endtask

  typedef struct {
    logic [3:0]     sv;
    logic [COL*W-1:0] s;
    logic           rdy;
    logic           vld;
    int             col;
    sum_word_t      dat;
    logic           lst;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] sv, input logic [COL*W-1:0] s, input logic rdy,
                              input logic vld, input int col, input sum_word_t dat, input logic lst);
    vec_t v;
    v.sv = sv; v.s = s; v.rdy = rdy; v.vld = vld; v.col = col; v.dat = dat; v.lst = lst;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    logic [COL*W-1:0] four;
    logic pv, pr, pl;
    sum_word_t pd;
    logic [1:0] pc;

    rst = 1; cfg_line_burst = 0; clear_err = 0; out_ready = 1; sum = '0; sum_valid = '0;
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data,  0);
    chk("rst_col",   out_col,   0);
    chk("rst_last",  out_last,  0);
    chk("rst_full",  col_full,  0);
    chk("rst_ovf",   overflow,  0);

    // Four simultaneous words drained in column order, then a stall/hold sequence.
    four = {24'h000013, 24'h000012, 24'h000011, 24'h000010};
    tbl[0] = mk(4'hF, four,     1, 0, 0, 24'h0,  0);
    tbl[1] = mk(4'h0, '0,       1, 1, 0, 24'h10, 0);
    tbl[2] = mk(4'h0, '0,       1, 1, 1, 24'h11, 0);
    tbl[3] = mk(4'h0, '0,       1, 1, 2, 24'h12, 0);
    tbl[4] = mk(4'h0, '0,       1, 1, 3, 24'h13, 0);
    tbl[5] = mk(4'h0, '0,       1, 0, 0, 24'h0,  0);
    tbl[6] = mk(4'h1, 96'h55,   0, 0, 0, 24'h0,  0);
    tbl[7] = mk(4'h0, '0,       0, 1, 0, 24'h55, 0);
    tbl[8] = mk(4'h0, '0,       0, 1, 0, 24'h55, 0);
    tbl[9] = mk(4'h0, '0,       1, 0, 0, 24'h0,  0);
    cfg_line_burst = 0;
    for (int i = 0; i < 10; i++) begin
      sum = tbl[i].s; sum_valid = tbl[i].sv; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_col", i),  out_col,  tbl[i].col);
        chk($sformatf("tbl%0d_data", i), out_data, tbl[i].dat);
        chk($sformatf("tbl%0d_last", i), out_last, tbl[i].lst);
      end
    end

    // Line-burst mode: column 0's whole line, then column 1's.
    do_reset();
    cfg_line_burst = 1; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sum = '0;
      sum[0 +: W] = 24'h100 + 24'(i);
      sum[W +: W] = 24'h200 + 24'(i);
      sum_valid = 4'b0011;
      tick();
    end
    drain(8, 30);
    for (int k = 0; k < 8 && k < got_d.size(); k++) begin
      chk($sformatf("burst%0d_col", k),  got_c[k], k / 4);
      chk($sformatf("burst%0d_data", k), got_d[k], ((k < 4) ? 24'h100 : 24'h200) + 24'(k % 4));
      chk($sformatf("burst%0d_last", k), got_l[k], (k % 4) == 3);
      chk($sformatf("burst%0d_gap", k),  got_t[k] - got_t[0], k);
    end

    // Overflow on column 2 behind an occupied, stalled output register.
    do_reset();
    cfg_line_burst = 0; out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      sum = '0;
      sum[0 +: W]   = 24'hAA;
      sum[2*W +: W] = 24'h300 + 24'(i);
      sum_valid = (i == 0) ? 4'b0101 : 4'b0100;
      tick();
      if (i == 6) chk("ovf_full_after7", col_full[2], 0);
      if (i == 7) begin
        chk("ovf_full_after8", col_full[2], 1);
        chk("ovf_flag_after8", overflow[2], 0);
      end
      if (i == 8) chk("ovf_flag_after9", overflow[2], 1);
    end
    sum[2*W +: W] = 24'h309; sum_valid = 4'b0100; clear_err = 1;
    tick();
    chk("ovf_clear_vs_event", overflow[2], 1);
    sum_valid = '0;
    tick();
    chk("ovf_cleared", overflow[2], 0);
    chk("ovf_still_full", col_full[2], 1);
    clear_err = 0;
    drain(9, 40);
    if (got_d.size() == 9) begin
      chk("ovf_first", got_d[0], 24'hAA);
      for (int k = 1; k < 9; k++) chk($sformatf("ovf_word%0d", k), got_d[k], 24'h300 + 24'(k - 1));
    end

    // Toggling ready under continuous input: order preserved, outputs held while stalled.
    do_reset();
    cfg_line_burst = 0;
    for (int i = 0; i < 24; i++) begin
      out_ready = i[0];
      sum = '0;
      sum[0 +: W] = 24'h400 + 24'(i);
      sum_valid = (i < 12) ? 4'b0001 : 4'b0000;
      pv = out_valid; pd = out_data; pc = out_col; pl = out_last; pr = out_ready;
      tick();
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data",  out_data,  pd);
        chk("stall_col",   out_col,   pc);
        chk("stall_last",  out_last,  pl);
      end
    end
    drain(12, 30);
    for (int k = 0; k < 12 && k < got_d.size(); k++)
      chk($sformatf("toggle_word%0d", k), got_d[k], 24'h400 + 24'(k));

    // Reset during an active lock with three buffered words.
    do_reset();
    cfg_line_burst = 1; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      sum = '0; sum[0 +: W] = 24'h500 + 24'(i); sum_valid = 4'b0001;
      tick();
    end
    rst = 1; sum[0 +: W] = 24'h5FF; sum_valid = 4'b0001;
    tick();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_full",  col_full,  0);
    rst = 0; sum_valid = '0; out_ready = 1;
    got_d.delete(); got_c.delete(); got_l.delete(); got_t.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("midrst_empty%0d", i), out_valid, 0);
    end
    for (int i = 0; i < 4; i++) begin
      sum = '0; sum[0 +: W] = 24'h600 + 24'(i); sum_valid = 4'b0001;
      tick();
    end
    drain(4, 20);
    for (int k = 0; k < 4 && k < got_d.size(); k++) begin
      chk($sformatf("midrst_data%0d", k), got_d[k], 24'h600 + 24'(k));
      chk($sformatf("midrst_last%0d", k), got_l[k], k == 3);
    end

    // Randomized traffic against the reference model.
    do_reset();
    cfg_line_burst = 0;
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      sum       = {$urandom(), $urandom(), $urandom()};
      sum_valid = 4'($urandom()) & 4'($urandom());
      out_ready = ($urandom_range(0, 9) < 6);
      clear_err = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) cfg_line_burst = ~cfg_line_burst;
      tick();
    end
    rst = 0; clear_err = 0; sum_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
